// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/flag control and handshake status for a register-array FIFO
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [DEPTH-1:0] we,
  output logic [AW-1:0]    rd_sel,
  output logic             dout_en,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      data_count,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
);
  // State bits double as the registered handshake flags {wr_ack, wr_err, rd_ack, rd_err}
  typedef enum logic [3:0] {
    IDLE      = 4'b0000,
    WRITE     = 4'b1000,
    READ      = 4'b0010,
    WR_RD     = 4'b1010,
    WR_ERR    = 4'b0100,
    RD_ERR    = 4'b0001,
    WR_RD_ERR = 4'b1001,
    WR_ERR_RD = 4'b0110
  } state_t;
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr_ok, rd_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign data_count = count;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign rd_sel = rd_ptr;
  // Strobes are suppressed during reset so a concurrent request never touches the bank
  assign we = (wr_ok & ~reset_n) ? {{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr : '0;
  assign dout_en = rd_ok & ~reset_n;
  assign {wr_ack, wr_err, rd_ack, rd_err} = state;
  always_comb state_n = state_t'({wr_ok, wr_en & ~wr_ok, rd_ok, rd_en & ~rd_ok});
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      state <= state_n;
    end
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control block for the 8-entry register-array FIFO; the datapath is a bank of resettable 4-bit registers plus an output register.
- Owns the write/read pointers, occupancy count and full/empty flags.
- Generates one-hot write strobes for the register bank, the read-mux select and the output-register load.
- Reports per-request handshake status (ack/error) one cycle after each request.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous reset, active-high (1 = reset), sampled on the rising edge of clk.
- wr_en  input  1  write request; sampled on the rising edge.
- rd_en  input  1  read request; sampled on the rising edge.
- we  output  DEPTH  one-hot write strobe to the register bank; bit i loads entry i.
- rd_sel  output  AW  read-mux select; equals rd_ptr.
- dout_en  output  1  load enable for the FIFO output register.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- data_count  output  AW+1  current occupancy, 0..DEPTH.
- wr_ack  output  1  previous-cycle write accepted.
- wr_err  output  1  previous-cycle write rejected (FIFO was full).
- rd_ack  output  1  previous-cycle read accepted.
- rd_err  output  1  previous-cycle read rejected (FIFO was empty).

Behaviour:
- Internal registers: wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], state (encoding free).
- Reset, while reset_n=1 at an edge:
  - wr_ptr=0, rd_ptr=0, count=0, state=IDLE.
  - Outputs: we=0, dout_en=0, empty=1, full=0, data_count=0, all ack/err=0.
  - Reset overrides any concurrent request, including one mid-stream; FIFO contents become don't-care.
- Acceptance (combinational from current inputs and registers):
  - wr_ok = wr_en & ~full.
  - rd_ok = rd_en & ~empty.
- Datapath control:
  - we = wr_ok ? (1 << wr_ptr) : 0, asserted in the same cycle as the request.
  - dout_en = rd_ok.
  - rd_sel = rd_ptr.
  - The register bank captures din, and the output register captures entry[rd_ptr], on the same edge the request is sampled; read data is valid at dout the cycle after rd_en.
- Pointer and count update on the edge:
  - wr_ok: wr_ptr+1, wrapping DEPTH-1 -> 0.
  - rd_ok: rd_ptr+1, same wrap.
  - count: +1 if wr_ok only, -1 if rd_ok only, unchanged if both or neither.
- full, empty and data_count are decoded from the registered count, so they reflect state after the last edge.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both performed; count unchanged.
  - Empty: write performed, read rejected (rd_err); count becomes 1.
  - Full: read performed, write rejected (wr_err); count becomes DEPTH-1.
- State machine; next state is chosen from the request seen at each edge and is registered:
  - IDLE: no request.
  - WRITE: wr_ok only, no read request.
  - READ: rd_ok only, no write request.
  - WR_RD: wr_ok & rd_ok.
  - WR_ERR: wr_en & full, no accepted read.
  - RD_ERR: rd_en & empty, no accepted write.
  - Mixed cases assert both flags, e.g. wr_ok with rejected read, or rejected write with rd_ok.
- Handshake outputs are registered, one cycle after the request:
  - wr_ack = previous-cycle wr_ok.
  - wr_err = previous-cycle wr_en & ~wr_ok.
  - rd_ack = previous-cycle rd_ok.
  - rd_err = previous-cycle rd_en & ~rd_ok.
  - wr_ack and wr_err are never both 1; the same holds for rd_ack and rd_err.
- Invariants:
  - full and empty are never both 1.
  - data_count == (wr_ptr - rd_ptr) mod DEPTH, except when full, where the pointers are equal and count = DEPTH.

Test Plan:
- Reset: hold reset_n=1 for 2 cycles with wr_en=rd_en=1 -> empty=1, full=0, data_count=0, we=0, all ack/err=0.
- Fill: 8 consecutive writes from empty -> we walks 0x01..0x80, wr_ack=1 each following cycle, full=1 and data_count=8 after the 8th. A 9th write -> we=0, wr_err=1 next cycle, count stays 8.
- Drain: 8 reads from full -> rd_sel 0..7, dout_en=1 each cycle, data_count 7..0. A 9th read -> dout_en=0, rd_err=1, empty=1.
- Wrap-around: write 5, read 5, then write 6 -> we sequence 0x20,0x40,0x80,0x01,0x02,0x04; wr_ptr returns to 3; data_count=6.
- Simultaneous requests:
  - count=3: count stays 3, wr_ack=rd_ack=1.
  - Empty: count becomes 1, wr_ack=1 and rd_err=1.
  - Full: count becomes 7, rd_ack=1 and wr_err=1.
- Mid-stream reset: reset_n=1 while count=5 with wr_en=1 -> we=0, next cycle count=0, empty=1, wr_ack=0.
